uart_rx_os: RTL and testbench

//  Parametrised UART receiver with 16x oversampling, majority-vote bit sampling and false-start rejection.

---
 rtl/uart_rx_os_if.sv | 31 +++
 rtl/uart_rx_os.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// Receive-side word handshake between uart_rx_os and its consumer.
//   master : the receiver; drives data_out/data_valid/frame_err/parity_err/overrun, reads data_ready
//   slave  : the consumer; reads the word and status, drives data_ready
interface uart_rx_os_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output parity_err,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  parity_err,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// UART receiver with 16x oversampling, 3-sample majority vote per bit, false-start
// rejection, frame/overrun reporting and a one-word valid/ready holding register.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous reset, active low
//   rx       asynchronous serial line, idle high
//   rx_busy  high whenever the receiver is not idle
//   bus      uart_rx_os_if.master: data_out, data_valid, data_ready, frame_err, parity_err, overrun
module uart_rx_os #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rx,
    output logic         rx_busy,
    uart_rx_os_if.master bus
);
    localparam int unsigned OS_DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned OS_W   = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    state_e state_q, state_d;

    logic                 rx_meta_q, rx_s_q;
    logic [OS_W-1:0]      os_cnt_q;
    logic [CNT_W-1:0]     tcnt_q;
    logic [CNT_W-1:0]     bcnt_q;
    logic                 samp7_q, samp8_q;
    logic [DATA_BITS-1:0] sh_q;
    logic                 ferr_q;
    logic                 commit_q;
    logic                 rx_busy_q;

    logic [DATA_BITS-1:0] dout_q;
    logic                 dv_q, fe_q, pe_q, ov_q;

    logic tick_c, decide_c, bit_end_c, vote_c, accept_c, par_err_c;
    logic shift_en_c, par_cap_c, stop_dec_c, commit_c, bcnt_inc_c, frame_clr_c;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Oversampling tick generator and 16-tick position within the current bit
    assign tick_c    = (state_q != S_IDLE) && (os_cnt_q == OS_W'(OS_DIV - 1));
    assign decide_c  = tick_c && (tcnt_q == CNT_W'(9));
    assign bit_end_c = tick_c && (tcnt_q == CNT_W'(15));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            os_cnt_q <= '0;
            tcnt_q   <= '0;
        end else if (state_q == S_IDLE) begin
            os_cnt_q <= '0;
            tcnt_q   <= '0;
        end else if (tick_c) begin
            os_cnt_q <= '0;
            tcnt_q   <= tcnt_q + CNT_W'(1);
        end else begin
            os_cnt_q <= os_cnt_q + OS_W'(1);
        end
    end

    // Samples at ticks 7 and 8; the tick-9 sample is taken live at decision time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp7_q <= 1'b1;
            samp8_q <= 1'b1;
        end else begin
            if (tick_c && (tcnt_q == CNT_W'(7))) samp7_q <= rx_s_q;
            if (tick_c && (tcnt_q == CNT_W'(8))) samp8_q <= rx_s_q;
        end
    end

    assign vote_c = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!rx_s_q) state_d = S_START;
            S_START: begin
                if (decide_c && vote_c) state_d = S_IDLE;
                else if (bit_end_c)     state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end_c && (bcnt_q == CNT_W'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (bit_end_c) state_d = S_STOP;
`endif
            S_STOP: begin
                if (decide_c && (bcnt_q == CNT_W'(STOP_BITS - 1)))
                    state_d = vote_c ? S_IDLE : S_BREAK;
            end
            S_BREAK:  if (rx_s_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        shift_en_c  = 1'b0;
        par_cap_c   = 1'b0;
        stop_dec_c  = 1'b0;
        commit_c    = 1'b0;
        bcnt_inc_c  = 1'b0;
        frame_clr_c = 1'b0;
        case (state_q)
            S_IDLE: frame_clr_c = !rx_s_q;
            S_DATA: begin
                shift_en_c = decide_c;
                bcnt_inc_c = bit_end_c;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: par_cap_c = decide_c;
`endif
            S_STOP: begin
                stop_dec_c = decide_c;
                bcnt_inc_c = bit_end_c;
                commit_c   = decide_c && (bcnt_q == CNT_W'(STOP_BITS - 1));
            end
            default: ;
        endcase
    end

    // Bit index within the DATA or STOP field; restarts on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               bcnt_q <= '0;
        else if (state_d != state_q) bcnt_q <= '0;
        else if (bcnt_inc_c)         bcnt_q <= bcnt_q + CNT_W'(1);
    end

    // LSB-first shift register, stop-bit error accumulator and commit strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q      <= '0;
            ferr_q    <= 1'b0;
            commit_q  <= 1'b0;
            rx_busy_q <= 1'b0;
        end else begin
            if (shift_en_c) sh_q <= {vote_c, sh_q[DATA_BITS-1:1]};
            if (frame_clr_c)                  ferr_q <= 1'b0;
            else if (stop_dec_c && !vote_c)   ferr_q <= 1'b1;
            commit_q  <= commit_c;
            rx_busy_q <= (state_d != S_IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       par_bit_q <= 1'b0;
        else if (par_cap_c) par_bit_q <= vote_c;
    end

    assign par_err_c = ((^sh_q) ^ par_bit_q) != PARITY_ODD;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = PARITY_ODD ^ par_cap_c;
    assign par_err_c         = 1'b0;
`endif

    // Holding register: a commit while full and not being accepted drops the word
    assign accept_c = dv_q & bus.data_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
            fe_q   <= 1'b0;
            pe_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else if (commit_q && (!dv_q || accept_c)) begin
            dout_q <= sh_q;
            fe_q   <= ferr_q;
            pe_q   <= par_err_c;
            dv_q   <= 1'b1;
            ov_q   <= 1'b0;
        end else if (commit_q) begin
            ov_q   <= 1'b1;
        end else if (accept_c) begin
            dv_q   <= 1'b0;
            fe_q   <= 1'b0;
            pe_q   <= 1'b0;
            ov_q   <= 1'b0;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = dv_q;
    assign bus.frame_err  = fe_q;
    assign bus.parity_err = pe_q;
    assign bus.overrun    = ov_q;
    assign rx_busy        = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frame-level reference model (expected-word queue built from the
// transmitted frames and the consumer's ready policy), directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_uart_rx_os;
    localparam int unsigned CLK_FREQ   = 50_000_000;
    localparam int unsigned BAUD_RATE  = 400_000;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam bit          PARITY_ODD = 1'b0;
    localparam int unsigned OS_DIV     = CLK_FREQ / (BAUD_RATE * 16);
    localparam int          BIT        = int'(OS_DIV) * 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rx      = 1'b1;
    logic rx_busy;

    uart_rx_os_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_rx_os #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .rx     (rx),
        .rx_busy(rx_busy),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic                 ferr;
        logic                 perr;
        logic                 ovr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp        = 0;
    int   n_bad        = 0;
    int   valid_cycles = 0;
    int   accepts      = 0;
    logic [DATA_BITS-1:0] last_data = '0;
    logic last_ferr = 1'b0;
    logic last_perr = 1'b0;
    logic last_ovr  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules for one received word
    function automatic logic par_err_of(input logic [DATA_BITS-1:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
        return ((^d) ^ p) != PARITY_ODD;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic good_par(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    task automatic push_exp(input logic [DATA_BITS-1:0] d, input logic f, input logic p, input logic o);
        exp_t e;
        e.data = d; e.ferr = f; e.perr = p; e.ovr = o;
        exp_q.push_back(e);
    endtask

    // Drive the line for n clocks; always leaves time at posedge+1
    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame; the line is left at the stop level after stop_hold clocks of the last stop bit
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic pbit,
                              input logic stop_v, input int stop_hold);
        hold(1'b0, BIT);
        for (int i = 0; i < int'(DATA_BITS); i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold(pbit, BIT);
`else
        if (pbit === 1'bx) hold(1'b1, 0);
`endif
        for (int s = 0; s < int'(STOP_BITS) - 1; s++) hold(stop_v, BIT);
        hold(stop_v, stop_hold);
    endtask

    // Compare process: every cycle a word is presented it must match the head of the model queue
    always @(negedge clk) begin
        if (reset_n && bus.data_valid === 1'b1) begin
            valid_cycles++;
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus.data_valid), 32'd0);
            end else begin
                check("data_out",   32'(bus.data_out),   32'(exp_q[0].data));
                check("frame_err",  32'(bus.frame_err),  32'(exp_q[0].ferr));
                check("parity_err", 32'(bus.parity_err), 32'(exp_q[0].perr));
                if (bus.data_ready === 1'b1) begin
                    check("overrun_at_accept", 32'(bus.overrun), 32'(exp_q[0].ovr));
                    last_data = bus.data_out;
                    last_ferr = bus.frame_err;
                    last_perr = bus.parity_err;
                    last_ovr  = bus.overrun;
                    accepts++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_BITS-1:0] d;
        logic                 pbit;
        logic                 bad;
        int                   kind, n, acc0;

        bus.data_ready = 1'b0;
        reset_n        = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data_valid", 32'(bus.data_valid), 32'd0);
        check("rst_data_out",   32'(bus.data_out),   32'd0);
        check("rst_frame_err",  32'(bus.frame_err),  32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        check("rst_overrun",    32'(bus.overrun),    32'd0);
        check("rst_rx_busy",    32'(rx_busy),        32'd0);
        reset_n = 1'b1;
        hold(1'b1, 20);

        // 1: clean frame, consumer always ready
        bus.data_ready = 1'b1;
        valid_cycles   = 0;
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, good_par(8'hA5), 1'b1, BIT);
        hold(1'b1, BIT);
        check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
        check("t1_data",         32'(last_data),    32'hA5);
        check("t1_frame_err",    32'(last_ferr),    32'd0);
        check("t1_overrun",      32'(last_ovr),     32'd0);

        // 2: short low pulse is a false start
        valid_cycles = 0;
        hold(1'b0, BIT / 4);
        check("t2_busy_in_pulse", 32'(rx_busy), 32'd1);
        hold(1'b1, BIT - BIT / 4);
        check("t2_busy_after_bit", 32'(rx_busy), 32'd0);
        check("t2_no_word",        32'(valid_cycles), 32'd0);
        hold(1'b1, BIT);

        // 3: stop bit low, line held low for two bit times
        push_exp(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, good_par(8'h3C), 1'b0, 2 * BIT);
        check("t3_busy_while_low", 32'(rx_busy), 32'd1);
        hold(1'b1, 8);
        check("t3_busy_released", 32'(rx_busy),   32'd0);
        check("t3_data",          32'(last_data), 32'h3C);
        check("t3_frame_err",     32'(last_ferr), 32'd1);
        hold(1'b1, BIT);

        // 4: consumer stalled over two frames
        bus.data_ready = 1'b0;
        push_exp(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h11, good_par(8'h11), 1'b1, BIT);
        hold(1'b1, BIT / 2);
        send_frame(8'h22, good_par(8'h22), 1'b1, BIT);
        hold(1'b1, BIT);
        check("t4_valid_held", 32'(bus.data_valid), 32'd1);
        check("t4_data",       32'(bus.data_out),   32'h11);
        check("t4_overrun",    32'(bus.overrun),    32'd1);
        bus.data_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_valid_cleared",   32'(bus.data_valid), 32'd0);
        check("t4_overrun_cleared", 32'(bus.overrun),    32'd0);
        hold(1'b1, BIT);

`ifdef UART_RX_PARITY_EN
        // 5: parity bit wrong, then right
        push_exp(8'h07, 1'b0, par_err_of(8'h07, 1'b0), 1'b0);
        send_frame(8'h07, 1'b0, 1'b1, BIT);
        hold(1'b1, BIT);
        check("t5_parity_bad", 32'(last_perr), 32'(~PARITY_ODD));
        push_exp(8'h07, 1'b0, par_err_of(8'h07, 1'b1), 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, BIT);
        hold(1'b1, BIT);
        check("t5_parity_ok", 32'(last_perr), 32'(PARITY_ODD));
`endif

        // 6: reset in the middle of a data field
        d = 8'h55;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(d[i], BIT);
        hold(d[4], BIT / 2);
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_busy_in_reset",  32'(rx_busy),        32'd0);
        check("t6_valid_in_reset", 32'(bus.data_valid), 32'd0);
        reset_n = 1'b1;
        hold(1'b1, BIT);
        acc0 = accepts;
        push_exp(8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, good_par(8'h81), 1'b1, BIT);
        hold(1'b1, BIT);
        check("t6_data",       32'(last_data),       32'h81);
        check("t6_frame_err",  32'(last_ferr),       32'd0);
        check("t6_parity_err", 32'(last_perr),       32'd0);
        check("t6_one_word",   32'(accepts - acc0),  32'd1);

        // Random traffic: clean/bad frames, glitches, stalled bursts
        for (int u = 0; u < 30; u++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                hold(1'b0, int'($urandom_range(2, BIT / 3)));
                hold(1'b1, BIT + int'($urandom_range(0, BIT / 2)));
            end else if (kind <= 2) begin
                n = int'($urandom_range(2, 3));
                bus.data_ready = 1'b0;
                for (int k = 0; k < n; k++) begin
                    d    = DATA_BITS'($urandom);
                    bad  = ($urandom_range(0, 4) == 0);
                    pbit = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
                    if (k == 0) push_exp(d, bad, par_err_of(d, pbit), 1'b1);
                    send_frame(d, pbit, ~bad, BIT);
                    hold(1'b1, bad ? BIT + int'($urandom_range(0, BIT)) : int'($urandom_range(0, BIT / 2)));
                end
                hold(1'b1, int'($urandom_range(0, BIT)));
                bus.data_ready = 1'b1;
                hold(1'b1, 2);
            end else begin
                d    = DATA_BITS'($urandom);
                bad  = ($urandom_range(0, 5) == 0);
                pbit = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
                bus.data_ready = ($urandom_range(0, 1) == 1);
                push_exp(d, bad, par_err_of(d, pbit), 1'b0);
                send_frame(d, pbit, ~bad, BIT);
                hold(1'b1, bad ? BIT + int'($urandom_range(0, BIT)) : int'($urandom_range(0, BIT / 2)));
                bus.data_ready = 1'b1;
                hold(1'b1, 2);
            end
        end

        hold(1'b1, 2 * BIT);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
